// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall controller for the five-stage MIPS core.
//
// Decides every cycle whether the D-stage instruction may advance. It compares
// operand use times (tuse) in D against result-ready times (tnew) of the E and
// M producers. It also tracks the multi-cycle mult/div unit with a busy counter.
//
// Optional feature macro: HAZARD_STALL_CTRL_MD_EN
//   defined   -> mult/div busy counter and mult/div stall present
//   undefined -> counter removed, md_busy/md_cnt tied to 0, md inputs ignored
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES   busy cycles after a div/divu start   (1..15)
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   d_rs, d_rt             D-stage source registers
//   d_rs_tuse, d_rt_tuse   cycles until operand consumed (3 = unused)
//   d_is_md                D instruction touches the mult/div unit
//   e_wa, m_wa             E/M destination register (0 = no write)
//   e_tnew, m_tnew         cycles until E/M result is forwardable
//   e_md_start, e_md_div   mult/div start pulse in E; 1 = div, 0 = mult
//   stall, flush_e         hold PC and F/D; bubble into D/E (combinational)
//   md_busy, md_cnt        mult/div busy flag and remaining busy cycles
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic       d_is_md,
  input  logic [4:0] e_wa,
  input  logic [4:0] m_wa,
  input  logic [1:0] e_tnew,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       stall,
  output logic       flush_e,
  output logic       md_busy,
  output logic [3:0] md_cnt
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  // E and M matches are independent; the OR decides with no priority.
  // An unused operand (tuse = 3) never stalls since tnew <= 2.
  always_comb begin
    stall_rs = (d_rs != 5'd0) &&
               (((d_rs == e_wa) && (d_rs_tuse < e_tnew)) ||
                ((d_rs == m_wa) && (d_rs_tuse < m_tnew)));
    stall_rt = (d_rt != 5'd0) &&
               (((d_rt == e_wa) && (d_rt_tuse < e_tnew)) ||
                ((d_rt == m_wa) && (d_rt_tuse < m_tnew)));
  end

`ifdef HAZARD_STALL_CTRL_MD_EN
  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  // A start while the counter is running is ignored: no reload.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start && (md_cnt_q == 4'd0)) begin
      md_cnt_d = e_md_div ? DivLoad : MultLoad;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_cnt   = md_cnt_q;
  assign md_busy  = (md_cnt_q != 4'd0);
  // A start in E already blocks a D md instruction in the same cycle.
  assign stall_md = d_is_md & (e_md_start | md_busy);
`else
  logic unused_md;
  assign unused_md = ^{clk, reset, e_md_start, e_md_div, d_is_md,
                       4'(MULT_CYCLES), 4'(DIV_CYCLES)};

  assign md_cnt   = 4'd0;
  assign md_busy  = 1'b0;
  assign stall_md = 1'b0;
`endif

  assign stall   = stall_rs | stall_rt | stall_md;
  assign flush_e = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table for register
// hazards, hand-written mult/div sequences and randomized stimulus against a
// cycle-number-based reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;
`ifdef HAZARD_STALL_CTRL_MD_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic       d_is_md, e_md_start, e_md_div;
  logic       stall, flush_e, md_busy;
  logic [3:0] md_cnt;

  hazard_stall_ctrl #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_tuse (d_rs_tuse),
    .d_rt_tuse (d_rt_tuse),
    .d_is_md   (d_is_md),
    .e_wa      (e_wa),
    .m_wa      (m_wa),
    .e_tnew    (e_tnew),
    .m_tnew    (m_tnew),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .stall     (stall),
    .flush_e   (flush_e),
    .md_busy   (md_busy),
    .md_cnt    (md_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  // Last cycle in which the mult/div unit is busy; busy over (start, md_end].
  int md_end = -1;

  typedef struct {
    logic [4:0] rs;
    logic [1:0] rs_tu;
    logic [4:0] rt;
    logic [1:0] rt_tu;
    logic [4:0] ewa;
    logic [1:0] etn;
    logic [4:0] mwa;
    logic [1:0] mtn;
    bit         exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // An operand stalls if any producer writing it is not ready by use time.
  function automatic bit op_stalls(input int r, input int tuse);
    int wa[2];
    int tn[2];
    wa[0] = e_wa; tn[0] = e_tnew;
    wa[1] = m_wa; tn[1] = m_tnew;
    if (r == 0) return 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (wa[p] == r && tn[p] > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_cnt();
    return (MdEn && md_end >= cyc) ? md_end - cyc + 1 : 0;
  endfunction

  task automatic model_check();
    int ec;
    bit es;
    ec = exp_cnt();
    es = op_stalls(d_rs, d_rs_tuse) | op_stalls(d_rt, d_rt_tuse) |
         (MdEn && d_is_md && (e_md_start || ec != 0));
    check("stall", stall, es);
    check("flush_e", flush_e, es);
    check("md_cnt", md_cnt, ec);
    check("md_busy", md_busy, ec != 0);
  endtask

  // Update the model with this cycle's inputs, then advance one clock.
  task automatic tick();
    int ec;
    ec = exp_cnt();
    if (reset) md_end = cyc;
    else if (e_md_start && ec == 0) md_end = cyc + (e_md_div ? DivN : MultN);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    d_rs = 0; d_rt = 0; d_rs_tuse = 3; d_rt_tuse = 3; d_is_md = 0;
    e_wa = 0; m_wa = 0; e_tnew = 0; m_tnew = 0;
    e_md_start = 0; e_md_div = 0; reset = 0;
  endtask

  // Explicit expectation for hand sequences, followed by the model check.
  task automatic hand(input string name, input bit es, input int ec);
    #3;
    check({name, "_stall"}, stall, es);
    check({name, "_cnt"}, md_cnt, ec);
    model_check();
  endtask

  initial begin
    //               rs rsT rt rtT ewa etn mwa mtn exp
    vecs[0]  = '{5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1};
    vecs[1]  = '{5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0};
    vecs[2]  = '{5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0};
    vecs[3]  = '{5'd0, 2'd3, 5'd9, 2'd3, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0};
    vecs[4]  = '{5'd0, 2'd3, 5'd4, 2'd0, 5'd0, 2'd0, 5'd4, 2'd1, 1'b1};
    vecs[5]  = '{5'd0, 2'd3, 5'd4, 2'd1, 5'd0, 2'd0, 5'd4, 2'd1, 1'b0};
    vecs[6]  = '{5'd5, 2'd0, 5'd0, 2'd3, 5'd5, 2'd0, 5'd5, 2'd1, 1'b1};
    vecs[7]  = '{5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd5, 2'd0, 1'b1};
    vecs[8]  = '{5'd3, 2'd0, 5'd6, 2'd2, 5'd7, 2'd2, 5'd6, 2'd2, 1'b0};
    vecs[9]  = '{5'd3, 2'd0, 5'd7, 2'd1, 5'd7, 2'd2, 5'd6, 2'd2, 1'b1};
    vecs[10] = '{5'd31, 2'd2, 5'd31, 2'd2, 5'd1, 2'd2, 5'd31, 2'd2, 1'b0};
    vecs[11] = '{5'd2, 2'd3, 5'd2, 2'd0, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1};

    idle();
    reset = 1;
    @(posedge clk);
    #1;
    cyc = 1;
    md_end = -1;
    reset = 0;

    // Reset state with idle inputs.
    hand("reset", 1'b0, 0);
    check("reset_busy", md_busy, 0);
    tick();

    // Register hazard table.
    foreach (vecs[i]) begin
      idle();
      d_rs = vecs[i].rs; d_rs_tuse = vecs[i].rs_tu;
      d_rt = vecs[i].rt; d_rt_tuse = vecs[i].rt_tu;
      e_wa = vecs[i].ewa; e_tnew = vecs[i].etn;
      m_wa = vecs[i].mwa; m_tnew = vecs[i].mtn;
      #3;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp);
      check($sformatf("vec%0d_flush", i), flush_e, vecs[i].exp);
      model_check();
      tick();
    end

    // Mult with a D md instruction held.
    idle();
    d_is_md = 1; e_md_start = 1; e_md_div = 0;
    hand("mult_t0", MdEn, 0);
    tick();
    e_md_start = 0;
    for (int i = 1; i <= 6; i++) begin
      hand($sformatf("mult_t%0d", i), MdEn && i <= 5, (MdEn && i <= 5) ? 6 - i : 0);
      tick();
    end

    // Div, then an ignored start at T+3.
    idle();
    e_md_start = 1; e_md_div = 1;
    hand("div_t0", 1'b0, 0);
    tick();
    for (int i = 1; i <= 11; i++) begin
      idle();
      e_md_start = (i == 3);
      hand($sformatf("div_t%0d", i), 1'b0, (MdEn && i <= 10) ? 11 - i : 0);
      tick();
    end

    // Reset mid-div at T+4.
    idle();
    e_md_start = 1; e_md_div = 1;
    hand("rst_t0", 1'b0, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      idle();
      reset = (i == 4);
      hand($sformatf("rst_t%0d", i), 1'b0, (MdEn && i <= 4) ? 11 - i : 0);
      if (i == 5) check("rst_busy", md_busy, 0);
      tick();
    end

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      d_rs       = 5'($urandom_range(0, 5));
      d_rt       = 5'($urandom_range(0, 5));
      d_rs_tuse  = 2'($urandom_range(0, 3));
      d_rt_tuse  = 2'($urandom_range(0, 3));
      e_wa       = 5'($urandom_range(0, 5));
      m_wa       = 5'($urandom_range(0, 5));
      e_tnew     = 2'($urandom_range(0, 2));
      m_tnew     = 2'($urandom_range(0, 2));
      d_is_md    = 1'($urandom_range(0, 1));
      e_md_start = ($urandom_range(0, 5) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 99) == 0);
      #3;
      model_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall controller for the five-stage MIPS core. Every cycle it decides whether the instruction in D may advance. It does this by comparing register use times (Tuse) in D against result-ready times (Tnew) of producers in E and M. It also schedules the multi-cycle multiply/divide unit through an internal busy counter. Its `stall` output drives the PC hold input and the F/D register enable; `flush_e` inserts a bubble into the D/E register.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `d_rs`, `d_rt`  in  5  source register numbers of the D-stage instruction.
- `d_rs_tuse`, `d_rt_tuse`  in  2  cycles from D until the operand is consumed; 3 means unused.
- `d_is_md`  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `e_wa`, `m_wa`  in  5  destination register of the E/M instruction; 0 means no write.
- `e_tnew`, `m_tnew`  in  2  cycles until the E/M result is forwardable.
- `e_md_start`  in  1  mult/div start pulse for the instruction in E.
- `e_md_div`  in  1  qualifies `e_md_start`: 1 means div/divu, 0 means mult/multu.
- `stall`  out  1  hold PC and F/D; combinational.
- `flush_e`  out  1  bubble into D/E; always equals `stall`.
- `md_busy`  out  1  mult/div unit busy; registered-derived.
- `md_cnt`  out  4  remaining busy cycles; visible for debug.

## Operation
- Register hazard:
  - `stall_rs` = (`d_rs`≠0) & ((`d_rs`==`e_wa` & `d_rs_tuse` < `e_tnew`) | (`d_rs`==`m_wa` & `d_rs_tuse` < `m_tnew`)).
  - `stall_rt` uses the same rule with `d_rt` and `d_rt_tuse`.
  - An E match is evaluated independently of an M match. The OR of both decides; there is no priority.
  - An unused operand (tuse = 3) can never stall, because tnew ≤ 2.
- Mult/div hazard: `stall_md` = `d_is_md` & (`e_md_start` | `md_busy`).
- `stall` = `stall_rs` | `stall_rt` | `stall_md`. `flush_e` = `stall`.
- Busy counter `md_cnt` (4 bits):
  - On reset it clears to 0.
  - If `e_md_start` and `md_cnt`==0, load `DIV_CYCLES` when `e_md_div`=1, else `MULT_CYCLES`.
  - Otherwise, if `md_cnt`≠0, decrement by 1.
  - `e_md_start` while `md_cnt`≠0 is ignored. The count continues and no reload happens.
  - `md_busy` = (`md_cnt`≠0).
- Both parameters must be in 1..15. Out-of-range values are a configuration error and are not checked in hardware.

## Timing
- Reset values: `md_cnt`=0, `md_busy`=0. `stall` and `flush_e` are 0 whenever all inputs are idle.
- Reset mid-operation: the counter clears at that edge, and `md_busy` is 0 in the following cycle.
- `stall` and `flush_e` are combinational, valid in the same cycle as their inputs. There is no registered delay.
- Cycle T has `e_md_start`=1, `e_md_div`=0:
  - Cycle T: `md_busy`=0, but a D md instruction already stalls through `e_md_start`.
  - Cycles T+1..T+5: `md_busy`=1, with `md_cnt` = 5, 4, 3, 2, 1.
  - Cycle T+6: `md_busy`=0. A stalled D md instruction advances at the end of T+6.
- Division follows the same pattern, with 10 busy cycles over T+1..T+10.
- A stall lasts exactly as long as its condition holds. Because E receives bubbles, a register stall clears once the producer moves on and its tnew drops.
- Simultaneous register and md hazards give a single `stall`; the counter is unaffected.

## Configuration
- `HAZARD_STALL_CTRL_MD_EN` defined:
  - The busy counter and `stall_md` are present as described above.
- Not defined:
  - The counter is removed.
  - `md_busy` and `md_cnt` are tied to 0.
  - `stall_md` is 0.
  - `e_md_start`, `e_md_div` and `d_is_md` are ignored.
  - `stall` depends only on register hazards.

## Test plan
- Load-use: `d_rs`=8, `d_rs_tuse`=1, `e_wa`=8, `e_tnew`=2 -> `stall`=`flush_e`=1. Changing to `e_tnew`=1 -> `stall`=0.
- $0 and unused operand: `d_rs`=0, `e_wa`=0, `e_tnew`=2 -> `stall`=0. `d_rt`=9, `d_rt_tuse`=3, `m_wa`=9, `m_tnew`=2 -> `stall`=0.
- M-stage hazard: `d_rt`=4, `d_rt_tuse`=0, `m_wa`=4, `m_tnew`=1 -> `stall`=1. Setting `d_rt_tuse`=1 -> `stall`=0.
- Mult: pulse `e_md_start` with `e_md_div`=0 at T, with `d_is_md`=1 held -> `stall`=1 over T..T+5 and `md_cnt` = 5..1 over T+1..T+5. At T+6, `stall`=0.
- Div, then a start while busy: div start at T, second `e_md_start` at T+3 -> `md_cnt` continues 7, 6, … with no reload, and `md_busy` falls at T+11.
- Reset mid-div: assert `reset` at T+4 -> `md_cnt`=0 and `md_busy`=0 at T+5. With the macro undefined, any md stimulus -> `md_busy`=0 and `stall` depends only on register hazards.
